// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// IFU_MISALIGN_CHK_EN adds the TRAP state for misaligned jump targets.
package ifu_fetch_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INST_W-1:0]      INST_NOP         = 32'h0000_0013;
   localparam logic [INST_ADDR_W-1:0] ADDR_ALIGN_MASK  = 32'h0000_0003;
   localparam logic [INST_ADDR_W-1:0] PC_STEP          = 32'd4;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1
`ifdef IFU_MISALIGN_CHK_EN
      ,
      ST_TRAP = 2'd2
`endif
   } state_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: ROM address/data, redirect request and the IF/ID handshake.
// misalign_o exists only when IFU_MISALIGN_CHK_EN is defined.
interface ifu_fetch_if;
   import ifu_fetch_pkg::*;

   logic                   jump_i;
   logic [INST_ADDR_W-1:0] jump_addr_i;
   logic                   id_ready_i;
   logic [INST_W-1:0]      inst_i;
   logic                   ce_o;
   logic [INST_ADDR_W-1:0] pc_o;
   logic                   id_valid_o;
   logic [INST_ADDR_W-1:0] id_pc_o;
   logic [INST_W-1:0]      id_inst_o;
`ifdef IFU_MISALIGN_CHK_EN
   logic                   misalign_o;

   modport master (
      input  jump_i, jump_addr_i, id_ready_i, inst_i,
      output ce_o, pc_o, id_valid_o, id_pc_o, id_inst_o, misalign_o
   );
   modport slave (
      output jump_i, jump_addr_i, id_ready_i, inst_i,
      input  ce_o, pc_o, id_valid_o, id_pc_o, id_inst_o, misalign_o
   );
`else
   modport master (
      input  jump_i, jump_addr_i, id_ready_i, inst_i,
      output ce_o, pc_o, id_valid_o, id_pc_o, id_inst_o
   );
   modport slave (
      output jump_i, jump_addr_i, id_ready_i, inst_i,
      input  ce_o, pc_o, id_valid_o, id_pc_o, id_inst_o
   );
`endif

endinterface

// File: rtl/ifu_id_reg.sv
// IF/ID output register: holds the delivered instruction and its PC.
// Priority: flush > load > clear > hold.
module ifu_id_reg
   import ifu_fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   flush,
   input  logic                   clear,
   input  logic [INST_ADDR_W-1:0] pc,
   input  logic [INST_W-1:0]      inst,
   output logic                   valid,
   output logic [INST_ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0]      id_inst
);

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid   <= 1'b0;
         id_pc   <= '0;
         id_inst <= INST_NOP;
      end else if (flush) begin
         valid   <= 1'b0;
         id_inst <= INST_NOP;
      end else if (load) begin
         valid   <= 1'b1;
         id_pc   <= pc;
         id_inst <= inst;
      end else if (clear) begin
         valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: PC/state control in front of a combinational ROM.
// IFU_MISALIGN_CHK_EN traps misaligned jump targets instead of truncating them.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   ifu_fetch_if.master bus
);

   state_t                 state, state_n;
   logic [INST_ADDR_W-1:0] pc, pc_n;
   logic                   ce, adv, load, flush, clear;
   logic                   id_valid;
   logic [INST_ADDR_W-1:0] id_pc;
   logic [INST_W-1:0]      id_inst;

   assign ce  = (state == ST_RUN);
   assign adv = ce & (~id_valid | bus.id_ready_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_BOOT;
         pc    <= RESET_PC;
      end else begin
         state <= state_n;
         pc    <= pc_n;
      end
   end

   // NOTE: defaults first so no path through this block can infer a latch.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      load    = 1'b0;
      flush   = 1'b0;
      clear   = 1'b0;
      if (bus.jump_i) begin
         flush = 1'b1;
`ifdef IFU_MISALIGN_CHK_EN
         pc_n    = bus.jump_addr_i;
         state_n = ((bus.jump_addr_i & ADDR_ALIGN_MASK) != '0) ? ST_TRAP : ST_RUN;
`else
         pc_n    = bus.jump_addr_i & ~ADDR_ALIGN_MASK;
         state_n = ST_RUN;
`endif
      end else begin
         case (state)
            ST_BOOT: begin
               state_n = ST_RUN;
               clear   = id_valid & bus.id_ready_i;
            end
            ST_RUN: begin
               if (adv) begin
                  load = 1'b1;
                  pc_n = pc + PC_STEP;
               end
            end
`ifdef IFU_MISALIGN_CHK_EN
            ST_TRAP: clear = id_valid & bus.id_ready_i;
`endif
            default: state_n = ST_BOOT;
         endcase
      end
   end

   ifu_id_reg u_id_reg (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .flush   (flush),
      .clear   (clear),
      .pc      (pc),
      .inst    (bus.inst_i),
      .valid   (id_valid),
      .id_pc   (id_pc),
      .id_inst (id_inst)
   );

   assign bus.ce_o       = ce;
   assign bus.pc_o       = pc;
   assign bus.id_valid_o = id_valid;
   assign bus.id_pc_o    = id_pc;
   assign bus.id_inst_o  = id_inst;
`ifdef IFU_MISALIGN_CHK_EN
   assign bus.misalign_o = (state == ST_TRAP);
`endif

endmodule
